// File: rtl/tl_pkg.sv
// Shared definitions for the traffic light controller and its monitor:
// phase and error encodings, the phase successor rule and default dwell times.
package tl_pkg;

  localparam logic [1:0] PH_NONE   = 2'd0;
  localparam logic [1:0] PH_RED    = 2'd1;
  localparam logic [1:0] PH_GREEN  = 2'd2;
  localparam logic [1:0] PH_YELLOW = 2'd3;

  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_ENCODING    = 3'd1;
  localparam logic [2:0] ERR_ORDER       = 3'd2;
  localparam logic [2:0] ERR_DWELL_SHORT = 3'd3;
  localparam logic [2:0] ERR_DWELL_LONG  = 3'd4;

  localparam int DEF_RED_CYC    = 5;
  localparam int DEF_GREEN_CYC  = 4;
  localparam int DEF_YELLOW_CYC = 2;

  typedef enum logic {
    ST_SYNC  = 1'b0,
    ST_TRACK = 1'b1
  } tl_mon_state_e;

  function automatic logic [1:0] tl_next(input logic [1:0] p);
    case (p)
      PH_RED:    tl_next = PH_GREEN;
      PH_GREEN:  tl_next = PH_YELLOW;
      PH_YELLOW: tl_next = PH_RED;
      default:   tl_next = PH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tl_light_decode.sv
// Combinational decode of the three lamp lines into a one-hot validity flag
// and the phase they represent.
module tl_light_decode
  import tl_pkg::*;
(
  input  logic       red_i,
  input  logic       yellow_i,
  input  logic       green_i,
  output logic       valid_o,
  output logic [1:0] phase_o
);

  always_comb begin
    valid_o = 1'b1;
    phase_o = PH_NONE;
    case ({red_i, green_i, yellow_i})
      3'b100:  phase_o = PH_RED;
      3'b010:  phase_o = PH_GREEN;
      3'b001:  phase_o = PH_YELLOW;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker of the traffic light outputs: one-hot encoding, phase order
// and per-phase dwell, plus a saturating count of fully legal light cycles.
module traffic_light_monitor
  import tl_pkg::*;
#(
  parameter int RED_CYC    = DEF_RED_CYC,
  parameter int GREEN_CYC  = DEF_GREEN_CYC,
  parameter int YELLOW_CYC = DEF_YELLOW_CYC,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  output logic             locked,
  output logic [1:0]       phase,
  output logic             err_valid,
  output logic [2:0]       err_code,
  output logic             err_sticky,
  output logic             cycle_done,
  output logic [CNT_W-1:0] cycles_ok
);

  logic             s_valid;
  logic [1:0]       s_phase;

  tl_mon_state_e    state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             first_q, first_d;
  logic             clean_q, clean_d;
  logic             inv_run_q, inv_run_d;
  logic             err_valid_q, err_valid_d;
  logic [2:0]       err_code_q, err_code_d;
  logic             err_sticky_q;
  logic             cycle_done_q, cycle_done_d;
  logic [CNT_W-1:0] cycles_ok_q;

  tl_light_decode u_decode (
    .red_i    (red),
    .yellow_i (yellow),
    .green_i  (green),
    .valid_o  (s_valid),
    .phase_o  (s_phase)
  );

  function automatic logic [CNT_W-1:0] cyc_of(input logic [1:0] p);
    case (p)
      PH_RED:    cyc_of = CNT_W'(RED_CYC);
      PH_GREEN:  cyc_of = CNT_W'(GREEN_CYC);
      PH_YELLOW: cyc_of = CNT_W'(YELLOW_CYC);
      default:   cyc_of = '0;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    dwell_d      = dwell_q;
    first_d      = first_q;
    clean_d      = clean_q;
    inv_run_d    = 1'b0;
    err_valid_d  = 1'b0;
    err_code_d   = err_code_q;
    cycle_done_d = 1'b0;

    if (!s_valid) begin
      state_d   = ST_SYNC;
      phase_d   = PH_NONE;
      dwell_d   = '0;
      first_d   = 1'b0;
      clean_d   = 1'b0;
      inv_run_d = 1'b1;
      // Only the first sample of an invalid run is reported.
      if (!inv_run_q) begin
        err_valid_d = 1'b1;
        err_code_d  = ERR_ENCODING;
      end
    end else if (state_q == ST_SYNC) begin
      state_d = ST_TRACK;
      phase_d = s_phase;
      dwell_d = CNT_W'(1);
      first_d = 1'b1;
      clean_d = 1'b0;
    end else if (s_phase == phase_q) begin
      if (!(&dwell_q)) dwell_d = dwell_q + CNT_W'(1);
      if (dwell_q == cyc_of(phase_q)) begin
        err_valid_d = 1'b1;
        err_code_d  = ERR_DWELL_LONG;
        clean_d     = 1'b0;
      end
    end else if (s_phase != tl_next(phase_q)) begin
      phase_d     = s_phase;
      dwell_d     = CNT_W'(1);
      first_d     = 1'b1;
      clean_d     = 1'b0;
      err_valid_d = 1'b1;
      err_code_d  = ERR_ORDER;
    end else begin
      phase_d = s_phase;
      dwell_d = CNT_W'(1);
      first_d = 1'b0;
      if (!first_q && (dwell_q < cyc_of(phase_q))) begin
        err_valid_d = 1'b1;
        err_code_d  = ERR_DWELL_SHORT;
        clean_d     = 1'b0;
      end else if (s_phase == PH_RED) begin
        // A legal red entry both closes the previous window and opens a new one.
        cycle_done_d = clean_q;
        clean_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_SYNC;
      phase_q      <= PH_NONE;
      dwell_q      <= '0;
      first_q      <= 1'b0;
      clean_q      <= 1'b0;
      inv_run_q    <= 1'b0;
      err_valid_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_sticky_q <= 1'b0;
      cycle_done_q <= 1'b0;
      cycles_ok_q  <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      dwell_q      <= dwell_d;
      first_q      <= first_d;
      clean_q      <= clean_d;
      inv_run_q    <= inv_run_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      err_sticky_q <= err_sticky_q | err_valid_d;
      cycle_done_q <= cycle_done_d;
      if (cycle_done_d && !(&cycles_ok_q)) cycles_ok_q <= cycles_ok_q + CNT_W'(1);
    end
  end

  assign locked     = (state_q == ST_TRACK);
  assign phase      = phase_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign err_sticky = err_sticky_q;
  assign cycle_done = cycle_done_q;
  assign cycles_ok  = cycles_ok_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed light sequences plus random phase
// streams, every cycle compared against a sample-level reference model.
module tb_traffic_light_monitor;

  localparam int RED_CYC    = 5;
  localparam int GREEN_CYC  = 4;
  localparam int YELLOW_CYC = 2;
  localparam int CNT_W      = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             red, yellow, green;
  logic             locked;
  logic [1:0]       phase;
  logic             err_valid;
  logic [2:0]       err_code;
  logic             err_sticky;
  logic             cycle_done;
  logic [CNT_W-1:0] cycles_ok;

  int n_checks = 0;
  int n_errors = 0;
  int err_pulses = 0;

  // Reference model state: integers, unbounded dwell
  int m_locked, m_phase, m_dwell, m_first, m_winbad, m_inv;
  int e_err_valid, e_err_code, e_sticky, e_done, e_ok;

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .RED_CYC(RED_CYC), .GREEN_CYC(GREEN_CYC), .YELLOW_CYC(YELLOW_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .red(red), .yellow(yellow), .green(green),
    .locked(locked), .phase(phase), .err_valid(err_valid), .err_code(err_code),
    .err_sticky(err_sticky), .cycle_done(cycle_done), .cycles_ok(cycles_ok)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int req_cyc(input int p);
    return (p == 1) ? RED_CYC : (p == 2) ? GREEN_CYC : YELLOW_CYC;
  endfunction

  task automatic model_lock(input int p);
    m_locked = 1; m_phase = p; m_dwell = 1; m_first = 1; m_winbad = 1;
  endtask

  task automatic model_step(input bit rst, input bit r, input bit y, input bit g);
    int code;
    int p;
    bit short_d;
    code = 0;
    e_err_valid = 0;
    e_done = 0;
    if (rst) begin
      m_locked = 0; m_phase = 0; m_dwell = 0; m_first = 0; m_winbad = 1; m_inv = 0;
      e_err_code = 0; e_sticky = 0; e_ok = 0;
      return;
    end
    if (int'(r) + int'(y) + int'(g) != 1) begin
      if (m_inv == 0) code = 1;
      m_inv = 1; m_locked = 0; m_phase = 0; m_dwell = 0; m_first = 0; m_winbad = 1;
    end else begin
      m_inv = 0;
      p = r ? 1 : (g ? 2 : 3);
      if (m_locked == 0) begin
        model_lock(p);
      end else if (p == m_phase) begin
        m_dwell++;
        if (m_dwell == req_cyc(p) + 1) begin
          code = 4;
          m_winbad = 1;
        end
      end else if (p != (m_phase % 3) + 1) begin
        code = 2;
        model_lock(p);
      end else begin
        short_d = (m_dwell < req_cyc(m_phase)) && (m_first == 0);
        if (short_d) code = 3;
        if (p == 1) begin
          if (!short_d && m_winbad == 0) begin
            e_done = 1;
            if (e_ok < (1 << CNT_W) - 1) e_ok++;
          end
          m_winbad = short_d ? 1 : 0;
        end else if (short_d) begin
          m_winbad = 1;
        end
        m_phase = p; m_dwell = 1; m_first = 0;
      end
    end
    if (code != 0) begin
      e_err_valid = 1;
      e_err_code = code;
      e_sticky = 1;
    end
  endtask

  task automatic step(input bit rst, input bit r, input bit y, input bit g);
    reset = rst; red = r; yellow = y; green = g;
    @(posedge clk);
    #1;
    model_step(rst, r, y, g);
    if (err_valid) err_pulses++;
    check("locked", int'(locked), m_locked);
    check("phase", int'(phase), m_phase);
    check("err_valid", int'(err_valid), e_err_valid);
    check("err_code", int'(err_code), e_err_code);
    check("err_sticky", int'(err_sticky), e_sticky);
    check("cycle_done", int'(cycle_done), e_done);
    check("cycles_ok", int'(cycles_ok), e_ok);
  endtask

  // Hold phase p (1 R, 2 G, 3 Y) for n cycles
  task automatic lights(input int p, input int n);
    for (int i = 0; i < n; i++) step(1'b0, p == 1, p == 3, p == 2);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int p, n, k;
    reset = 1'b1; red = 1'b1; yellow = 1'b0; green = 1'b0;
    do_reset();

    // Two clean cycles: only the second is counted
    lights(1, 5); lights(2, 4); lights(3, 2);
    lights(1, 5); lights(2, 4); lights(3, 2); lights(1, 1);
    check("tp1_cycles_ok", int'(cycles_ok), 1);
    check("tp1_sticky", int'(err_sticky), 0);

    // Long green, reported exactly once
    do_reset();
    err_pulses = 0;
    lights(1, 5); lights(2, 5);
    check("tp2_code", int'(err_code), 4);
    lights(3, 2); lights(1, 1);
    check("tp2_pulses", err_pulses, 1);

    // Short yellow
    do_reset();
    lights(1, 5); lights(2, 4); lights(3, 1); lights(1, 1);
    check("tp3_code", int'(err_code), 3);
    check("tp3_phase", int'(phase), 1);

    // Order error then relocked yellow, no short check on it
    do_reset();
    err_pulses = 0;
    lights(1, 5); lights(3, 1);
    check("tp4_code", int'(err_code), 2);
    lights(3, 1); lights(1, 5);
    check("tp4_pulses", err_pulses, 1);

    // Multiple lights for 3 cycles
    do_reset();
    err_pulses = 0;
    lights(1, 3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    lights(1, 1);
    check("tp5_pulses", err_pulses, 1);
    check("tp5_locked", int'(locked), 1);

    // Reset in mid-green after an error
    lights(2, 2);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    lights(2, 2);

    // Random phase streams with dwell jitter, order slips, glitches and resets
    do_reset();
    p = 1;
    for (int it = 0; it < 400; it++) begin
      k = $urandom_range(0, 99);
      if (k < 4) begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
          logic [2:0] bits;
          bits = 3'($urandom_range(0, 7));
          step(1'b0, bits[2], bits[1], bits[0]);
        end
      end else if (k < 6) begin
        step(1'b1, 1'b1, 1'b0, 1'b0);
      end
      if (k >= 6 && k < 12) p = $urandom_range(1, 3);
      else p = (p % 3) + 1;
      if ($urandom_range(0, 3) == 0) n = req_cyc(p) + $urandom_range(0, 2) - 1;
      else n = req_cyc(p);
      if (n < 1) n = 1;
      lights(p, n);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
